// File: rtl/nios2_cpu_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// nios2_cpu_oci_dct_packer
//
// Producer end of the OCI direct-compression trace (DCT) path. Instruction
// trace codes (CODE_W bits each) are shifted into a packing buffer of
// DEPTH codes. A full buffer, or a partial one that has been asked to flush,
// is handed to the trace FIFO as a single frame {count, buffer} over a
// valid/ready port. An end-of-test request drains whatever is left and then
// parks the block in an absorbing ENDED state. The OCI test bench samples
// test_ending/test_has_ended together with dct_buffer/dct_count.
//
// Optional feature macro: NIOS2_OCI_DCT_TIMEOUT_EN
//   Defined   : an idle counter flushes a partial buffer after TIMEOUT_CYCLES
//               cycles without new codes (RUN state only).
//   Undefined : partial frames leave only on flush_req or end_req.
//
// Ports
//   clk            in   1             rising-edge clock for all logic
//   reset          in   1             synchronous, active-high
//   trace_valid    in   1             trace_code valid this cycle
//   trace_code     in   CODE_W        01 taken, 10 not-taken, 11 exception, 00 seq
//   flush_req      in   1             pulse: emit the partial buffer
//   end_req        in   1             pulse: end of test, drain and stop
//   out_ready      in   1             FIFO accepts the frame
//   out_valid      out  1             frame valid
//   out_data       out  CNT_W+BUF_W   {count, buffer} of the emitted frame
//   dct_buffer     out  BUF_W         live packing buffer
//   dct_count      out  CNT_W         live fill count, 0..DEPTH
//   overflow       out  1             sticky: a code was dropped
//   test_ending    out  1             high while draining (ENDING)
//   test_has_ended out  1             high once drained (ENDED)
// -----------------------------------------------------------------------------
module nios2_cpu_oci_dct_packer #(
  parameter  int unsigned CODE_W = 2,
  parameter  int unsigned DEPTH  = 15,   // must satisfy DEPTH < 2**CNT_W
  parameter  int unsigned CNT_W  = 4,
  localparam int unsigned BUF_W  = CODE_W * DEPTH
`ifdef NIOS2_OCI_DCT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_valid,
  input  logic [CODE_W-1:0]      trace_code,
  input  logic                   flush_req,
  input  logic                   end_req,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [CNT_W+BUF_W-1:0] out_data,
  output logic [BUF_W-1:0]       dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  output logic                   overflow,
  output logic                   test_ending,
  output logic                   test_has_ended
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_ENDED  = 2'd2
  } state_t;

  state_t state;
  logic   flush_pending;

  // Decode of the current cycle.
  logic             is_full;
  logic             free;
  logic             in_run;
  logic             flush_eff;
  logic             emit;
  logic             accept;
  logic             drop;
  logic             timeout_flush;
  logic [CNT_W-1:0] count_next;
  logic [BUF_W-1:0] buffer_next;
  logic             pending_next;

  // ---------------------------------------------------------------------------
  // Cycle decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default at the top so no path can
  // leave it unassigned; that is what keeps the block free of inferred latches.
  always_comb begin
    is_full      = (dct_count == FULL_CNT);
    // The output register can take a new frame in the same cycle it hands
    // the old one off.
    free         = !out_valid || out_ready;
    in_run       = (state == ST_RUN);
    // Draining forces a flush regardless of the registered request.
    flush_eff    = flush_pending || (state == ST_ENDING);
    emit         = free && (state != ST_ENDED) &&
                   (is_full || (flush_eff && (dct_count != '0)));
    // A full buffer only accepts when it is emitted in the same cycle; the
    // incoming code then becomes the first code of the fresh buffer.
    accept       = in_run && trace_valid && (!is_full || free);
    drop         = in_run && trace_valid && is_full && !free;

    count_next   = dct_count;
    buffer_next  = dct_buffer;
    if (emit) begin
      count_next  = accept ? CNT_W'(1) : '0;
      buffer_next = accept ? {{(BUF_W-CODE_W){1'b0}}, trace_code} : '0;
    end else if (accept) begin
      count_next  = dct_count + CNT_W'(1);
      buffer_next = {dct_buffer[BUF_W-CODE_W-1:0], trace_code};
    end

    // A flush request arriving in the emit cycle applies to the new buffer.
    // A pending flush with nothing left to send is dropped at once.
    pending_next = 1'b0;
    unique case (state)
      ST_RUN: begin
        pending_next = (flush_pending && !emit) || flush_req || timeout_flush;
        if (count_next == '0) begin
          pending_next = 1'b0;
        end
      end
      ST_ENDING: pending_next = 1'b1;
      default:   pending_next = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packing buffer, output register and end-of-test FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register here is plain control/data state, so all of it is
      // reset; a mid-frame reset discards the buffer and any pending frame.
      state          <= ST_RUN;
      flush_pending  <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      overflow       <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      dct_buffer    <= buffer_next;
      dct_count     <= count_next;
      flush_pending <= pending_next;

      if (drop) begin
        overflow <= 1'b1;
      end

      // out_data only changes on emit, so it stays stable while held.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= {dct_count, dct_buffer};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        ST_RUN: begin
          // A code presented with end_req is accepted above before leaving RUN.
          if (end_req) begin
            state       <= ST_ENDING;
            test_ending <= 1'b1;
          end
        end
        ST_ENDING: begin
          if ((dct_count == '0) && !out_valid) begin
            state          <= ST_ENDED;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b1;
          end
        end
        default: begin
          // ENDED is absorbing until reset.
          state          <= ST_ENDED;
          test_ending    <= 1'b0;
          test_has_ended <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Idle-flush timer
  // ---------------------------------------------------------------------------
`ifdef NIOS2_OCI_DCT_TIMEOUT_EN
  logic [6:0] idle_cnt;

  // Behaves exactly like a flush_req pulse when the idle interval elapses.
  assign timeout_flush = in_run && (idle_cnt == 7'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!in_run || accept || (dct_count == '0) || timeout_flush) begin
      idle_cnt <= '0;
    end else if (!trace_valid) begin
      idle_cnt <= idle_cnt + 7'd1;
    end
  end
`else
  assign timeout_flush = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_cpu_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// tb_nios2_cpu_oci_dct_packer
//
// Directed bench for the DCT packer: reset state, full-frame emit, overlap of
// a new code with an emit, explicit flush (partial and empty), stalled output
// with overflow, mid-stall reset, and the end-of-test drain sequence.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_nios2_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        trace_valid;
  logic [1:0]  trace_code;
  logic        flush_req;
  logic        end_req;
  logic        out_ready;
  logic        out_valid;
  logic [33:0] out_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        test_ending;
  logic        test_has_ended;

  int checks   = 0;
  int failures = 0;

  nios2_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .trace_valid    (trace_valid),
    .trace_code     (trace_code),
    .flush_req      (flush_req),
    .end_req        (end_req),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected frames, built from the packing rule {count, codes oldest..newest}.
  localparam logic [29:0] BUF_01X15 = 30'h1555_5555;   // 15 x 2'b01
  localparam logic [29:0] BUF_10X15 = 30'h2AAA_AAAA;   // 15 x 2'b10

  initial begin
    reset       = 1'b1;
    trace_valid = 1'b0;
    trace_code  = 2'b00;
    flush_req   = 1'b0;
    end_req     = 1'b0;
    out_ready   = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_out_data", out_data, 34'd0);
    check("rst_count", 34'(dct_count), 34'd0);
    check("rst_buffer", 34'(dct_buffer), 34'd0);
    check("rst_overflow", 34'(overflow), 34'd0);
    check("rst_ending", 34'(test_ending), 34'd0);
    check("rst_ended", 34'(test_has_ended), 34'd0);
    reset = 1'b0;

    // ---------------- fill: 15 x 01 ----------------
    trace_valid = 1'b1;
    trace_code  = 2'b01;
    tick();
    check("fill_first_count", 34'(dct_count), 34'd1);
    check("fill_first_buffer", 34'(dct_buffer), 34'h1);
    for (int i = 1; i < 15; i++) tick();
    check("fill_full_count", 34'(dct_count), 34'd15);
    check("fill_full_buffer", 34'(dct_buffer), 34'(BUF_01X15));
    check("fill_full_no_valid", 34'(out_valid), 34'd0);
    trace_valid = 1'b0;
    tick();
    check("fill_emit_valid", 34'(out_valid), 34'd1);
    check("fill_emit_data", out_data, {4'd15, BUF_01X15});
    check("fill_emit_count", 34'(dct_count), 34'd0);
    check("fill_emit_buffer", 34'(dct_buffer), 34'd0);
    tick();
    check("fill_handoff_valid", 34'(out_valid), 34'd0);

    // ---------------- overlap: 16th code on emit cycle ----------------
    trace_valid = 1'b1;
    trace_code  = 2'b01;
    for (int i = 0; i < 15; i++) tick();
    check("ovl_full_count", 34'(dct_count), 34'd15);
    trace_code = 2'b11;
    tick();
    check("ovl_emit_valid", 34'(out_valid), 34'd1);
    check("ovl_emit_data", out_data, {4'd15, BUF_01X15});
    check("ovl_new_count", 34'(dct_count), 34'd1);
    check("ovl_new_buffer", 34'(dct_buffer), 34'h3);
    trace_valid = 1'b0;
    tick();
    check("ovl_handoff_valid", 34'(out_valid), 34'd0);
    check("ovl_keep_count", 34'(dct_count), 34'd1);
    // Flush the single leftover code.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("ovl_flush_pending_no_valid", 34'(out_valid), 34'd0);
    tick();
    check("ovl_flush_valid", 34'(out_valid), 34'd1);
    check("ovl_flush_data", out_data, {4'd1, 30'h3});
    check("ovl_flush_count", 34'(dct_count), 34'd0);
    tick();

    // ---------------- flush: 01,10,11 ----------------
    trace_valid = 1'b1;
    trace_code  = 2'b01;
    tick();
    trace_code = 2'b10;
    tick();
    trace_code = 2'b11;
    tick();
    trace_valid = 1'b0;
    check("flush_count", 34'(dct_count), 34'd3);
    check("flush_buffer", 34'(dct_buffer), 34'h1B);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    check("flush_valid", 34'(out_valid), 34'd1);
    check("flush_data", out_data, {4'd3, 30'h1B});
    check("flush_count_cleared", 34'(dct_count), 34'd0);
    tick();
    check("flush_handoff", 34'(out_valid), 34'd0);
    // Flush with an empty buffer emits nothing.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_empty_v0", 34'(out_valid), 34'd0);
    tick();
    check("flush_empty_v1", 34'(out_valid), 34'd0);
    tick();
    check("flush_empty_v2", 34'(out_valid), 34'd0);
    check("flush_empty_count", 34'(dct_count), 34'd0);

    // ---------------- stall: out_ready low, 31 x 10 ----------------
    out_ready   = 1'b0;
    trace_valid = 1'b1;
    trace_code  = 2'b10;
    for (int i = 0; i < 30; i++) tick();
    check("stall_no_overflow_yet", 34'(overflow), 34'd0);
    check("stall_second_full", 34'(dct_count), 34'd15);
    tick();
    trace_valid = 1'b0;
    check("stall_overflow", 34'(overflow), 34'd1);
    check("stall_held_valid", 34'(out_valid), 34'd1);
    check("stall_held_data", out_data, {4'd15, BUF_10X15});
    check("stall_count", 34'(dct_count), 34'd15);
    check("stall_buffer", 34'(dct_buffer), 34'(BUF_10X15));
    tick();
    tick();
    check("stall_hold_valid", 34'(out_valid), 34'd1);
    check("stall_hold_data", out_data, {4'd15, BUF_10X15});
    check("stall_overflow_sticky", 34'(overflow), 34'd1);

    // ---------------- reset mid-stall ----------------
    reset = 1'b1;
    tick();
    check("mrst_out_valid", 34'(out_valid), 34'd0);
    check("mrst_count", 34'(dct_count), 34'd0);
    check("mrst_buffer", 34'(dct_buffer), 34'd0);
    check("mrst_overflow", 34'(overflow), 34'd0);
    check("mrst_ending", 34'(test_ending), 34'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    // Back in RUN: a code is honoured.
    trace_valid = 1'b1;
    trace_code  = 2'b01;
    tick();
    trace_valid = 1'b0;
    check("mrst_run_accept", 34'(dct_count), 34'd1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    check("mrst_flush_data", out_data, {4'd1, 30'h1});
    tick();
    check("mrst_flush_handoff", 34'(out_valid), 34'd0);

    // ---------------- end of test ----------------
    trace_valid = 1'b1;
    trace_code  = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    check("end_pre_count", 34'(dct_count), 34'd4);
    // Fifth code together with end_req: accepted, then ENDING.
    end_req   = 1'b1;
    out_ready = 1'b0;
    tick();
    end_req     = 1'b0;
    trace_code  = 2'b11;   // stays valid but must be ignored from now on
    check("end_e1_ending", 34'(test_ending), 34'd1);
    check("end_e1_ended", 34'(test_has_ended), 34'd0);
    check("end_e1_count", 34'(dct_count), 34'd5);
    check("end_e1_buffer", 34'(dct_buffer), 34'h155);
    tick();
    check("end_e2_valid", 34'(out_valid), 34'd1);
    check("end_e2_data", out_data, {4'd5, 30'h155});
    check("end_e2_count", 34'(dct_count), 34'd0);
    check("end_e2_ending", 34'(test_ending), 34'd1);
    tick();
    tick();
    check("end_e4_valid", 34'(out_valid), 34'd1);
    check("end_e4_count_ignored", 34'(dct_count), 34'd0);
    check("end_e4_ending", 34'(test_ending), 34'd1);
    out_ready = 1'b1;
    tick();
    check("end_e5_handoff", 34'(out_valid), 34'd0);
    check("end_e5_ending", 34'(test_ending), 34'd1);
    tick();
    check("end_e6_ending", 34'(test_ending), 34'd0);
    check("end_e6_ended", 34'(test_has_ended), 34'd1);
    // ENDED ignores every request.
    trace_code = 2'b01;
    flush_req  = 1'b1;
    end_req    = 1'b1;
    tick();
    tick();
    tick();
    trace_valid = 1'b0;
    flush_req   = 1'b0;
    end_req     = 1'b0;
    check("ended_count", 34'(dct_count), 34'd0);
    check("ended_valid", 34'(out_valid), 34'd0);
    check("ended_sticky", 34'(test_has_ended), 34'd1);
    check("ended_not_ending", 34'(test_ending), 34'd0);
    check("ended_no_overflow", 34'(overflow), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
